uart_tx_arb: RTL and testbench

Packet-atomic round-robin arbiter that shares the single UART transmit FIFO (8-bit wide, 16 deep, 5-bit count) between NUM_REQ byte-stream requesters. It drives the FIFO's push strobe and write data directly. It uses the FIFO's registered occupancy count for back-pressure, so the FIFO is never pushed when full. A granted requester holds the FIFO until it marks the last byte of its packet. A watchdog releases the grant if that requester stalls mid-packet.

---
 rtl/uart_tx_arb_pkg.sv | 15 +
 rtl/uart_tx_arb_if.sv | 34 +++
 rtl/uart_tx_arb_rr_pick.sv | 42 ++++
 rtl/uart_tx_arb.sv | 113 +++++++++++
 tb/tb_uart_tx_arb.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared constants and state type for the UART TX arbiter slice.
package uart_tx_arb_pkg;

  localparam int UART_FIFO_WIDTH     = 8;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int UART_ARB_NUM_REQ    = 4;
  localparam int UART_ARB_TIMEOUT    = 64;

  typedef enum logic {
    UART_ARB_IDLE = 1'b0,
    UART_ARB_LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester byte streams, TX FIFO push side and arbiter status in one bundle.
interface uart_tx_arb_if
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = UART_ARB_NUM_REQ,
  parameter int FIFO_WIDTH     = UART_FIFO_WIDTH,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W,
  parameter int GRANT_W        = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_push;
  logic [FIFO_WIDTH-1:0]         fifo_data;
  logic [FIFO_COUNTER_W-1:0]     fifo_count;
  logic [GRANT_W-1:0]            grant_id;
  logic                          busy;
  logic                          stall_err;

  // Arbiter side: drives the FIFO push and the per-requester ready.
  modport master (
    input  req_valid, req_data, req_last, fifo_count,
    output req_ready, fifo_push, fifo_data, grant_id, busy, stall_err
  );

  // Requesters and FIFO side.
  modport slave (
    output req_valid, req_data, req_last, fifo_count,
    input  req_ready, fifo_push, fifo_data, grant_id, busy, stall_err
  );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: rotate requests so last_grant+1 is bit 0,
// priority-encode, then map the offset back to a requester index.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  localparam int unsigned N = NUM_REQ;

  logic [NUM_REQ-1:0] rot;
  logic [31:0]        start;
  logic [31:0]        off;
  logic               found;

  always_comb begin
    rot   = '0;
    start = (32'(last_grant) + 32'd1) % N;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i == (start + k) % N) rot[k] = req[i];
      end
    end

    found = 1'b0;
    off   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end

    any_req = found;
    winner  = IDW'((start + off) % N);
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-atomic round-robin arbiter feeding the shared UART TX FIFO, with a
// mid-packet stall watchdog.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = UART_ARB_NUM_REQ,
  parameter int FIFO_WIDTH     = UART_FIFO_WIDTH,
  parameter int FIFO_DEPTH     = UART_FIFO_DEPTH,
  parameter int FIFO_COUNTER_W = UART_FIFO_COUNTER_W,
  parameter int TIMEOUT        = UART_ARB_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  uart_tx_arb_if.master bus
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT);
  localparam logic [FIFO_COUNTER_W-1:0] DEPTH_C  = FIFO_COUNTER_W'(FIFO_DEPTH);
  localparam logic [CW-1:0]             IDLE_LIM = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]             IDLE_MAX = '1;

  arb_state_t     state_q;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] last_grant_q;
  logic [CW-1:0]  idle_cnt_q;
  logic           stall_q;

  logic [IDW-1:0] pick_id;
  logic           pick_any;

  logic                  space;
  logic                  lock;
  logic                  g_valid;
  logic                  g_last;
  logic                  push;
  logic [FIFO_WIDTH-1:0] g_data;
  logic [NUM_REQ-1:0]    ready;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .winner     (pick_id),
    .any_req    (pick_any)
  );

  // Explicit compare-select mux keeps data defined for any grant value.
  always_comb begin
    space   = (bus.fifo_count < DEPTH_C);
    lock    = (state_q == UART_ARB_LOCK);
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    ready   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDW'(i)) begin
        g_valid  = bus.req_valid[i];
        g_last   = bus.req_last[i];
        g_data   = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
        ready[i] = lock & space;
      end
    end
    push = lock & g_valid & space;
  end

  assign bus.req_ready = ready;
  assign bus.fifo_push = push;
  assign bus.fifo_data = g_data;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = lock;
  assign bus.stall_err = stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UART_ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
      idle_cnt_q   <= '0;
      stall_q      <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      unique case (state_q)
        UART_ARB_IDLE: begin
          if (pick_any) begin
            grant_q    <= pick_id;
            idle_cnt_q <= '0;
            state_q    <= UART_ARB_LOCK;
          end
        end
        UART_ARB_LOCK: begin
          if (push) begin
            idle_cnt_q <= '0;
            if (g_last) begin
              state_q      <= UART_ARB_IDLE;
              last_grant_q <= grant_q;
            end
          end else if (idle_cnt_q == IDLE_LIM) begin
            state_q      <= UART_ARB_IDLE;
            last_grant_q <= grant_q;
            stall_q      <= 1'b1;
          end else if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
        end
        default: state_q <= UART_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: packets, contention, back-pressure,
// watchdog, round-robin wrap and mid-packet reset.
module tb_uart_tx_arb;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arb_if #(.NUM_REQ(NR), .FIFO_WIDTH(W), .FIFO_COUNTER_W(5)) bif ();

  uart_tx_arb #(
    .NUM_REQ        (NR),
    .FIFO_WIDTH     (W),
    .FIFO_DEPTH     (16),
    .FIFO_COUNTER_W (5),
    .TIMEOUT        (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
    bif.req_valid[i]     = v;
    bif.req_data[i*W +: W] = d;
    bif.req_last[i]      = l;
  endtask

  task automatic clear_all();
    bif.req_valid = '0;
    bif.req_data  = '0;
    bif.req_last  = '0;
  endtask

  task automatic chk_push(input string tag, input int g, input logic [7:0] d);
    chk({tag, "_busy"},  32'(bif.busy), 32'd1);
    chk({tag, "_grant"}, 32'(bif.grant_id), 32'(g));
    chk({tag, "_push"},  32'(bif.fifo_push), 32'd1);
    chk({tag, "_data"},  32'(bif.fifo_data), 32'(d));
    chk({tag, "_ready"}, 32'(bif.req_ready), 32'(1 << g));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  32'(bif.busy), 32'd0);
    chk({tag, "_push"},  32'(bif.fifo_push), 32'd0);
    chk({tag, "_ready"}, 32'(bif.req_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};
    clear_all();
    bif.fifo_count = '0;
    rst = 1'b1;
    cyc();
    cyc();
    settle();
    chk("rst_grant", 32'(bif.grant_id), 32'd0);
    chk("rst_stall", 32'(bif.stall_err), 32'd0);
    chk_idle("rst");

    // Single 3-byte packet from requester 0.
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 8'hA1, 1'b0);
    settle();
    chk_idle("p1_arb");
    cyc(); settle();
    chk_push("p1_b0", 0, 8'hA1);
    cyc(); set_req(0, 1'b1, 8'hA2, 1'b0); settle();
    chk_push("p1_b1", 0, 8'hA2);
    cyc(); set_req(0, 1'b1, 8'hA3, 1'b1); settle();
    chk_push("p1_b2", 0, 8'hA3);
    cyc(); set_req(0, 1'b0, 8'h00, 1'b0); settle();
    chk_idle("p1_end");

    // Contention from reset: 1 then 2, one IDLE cycle between.
    cyc();
    rst = 1'b1;
    set_req(1, 1'b1, 8'h11, 1'b0);
    set_req(2, 1'b1, 8'h21, 1'b0);
    cyc(); rst = 1'b0; settle();
    chk_idle("c_arb");
    cyc(); settle();
    chk_push("c_r1b0", 1, 8'h11);
    cyc(); set_req(1, 1'b1, 8'h12, 1'b1); settle();
    chk_push("c_r1b1", 1, 8'h12);
    cyc(); set_req(1, 1'b0, 8'h00, 1'b0); settle();
    chk_idle("c_gap");
    cyc(); settle();
    chk_push("c_r2b0", 2, 8'h21);
    cyc(); set_req(2, 1'b1, 8'h22, 1'b1); settle();
    chk_push("c_r2b1", 2, 8'h22);
    cyc(); set_req(2, 1'b0, 8'h00, 1'b0); settle();
    chk_idle("c_end");

    // Full back-pressure on requester 0.
    cyc(); set_req(0, 1'b1, 8'h31, 1'b0); settle();
    chk_idle("bp_arb");
    cyc(); bif.fifo_count = 5'd16; settle();
    chk("bp_full_busy",  32'(bif.busy), 32'd1);
    chk("bp_full_grant", 32'(bif.grant_id), 32'd0);
    chk("bp_full_push",  32'(bif.fifo_push), 32'd0);
    chk("bp_full_ready", 32'(bif.req_ready), 32'd0);
    cyc(); settle();
    chk("bp_full2_push", 32'(bif.fifo_push), 32'd0);
    cyc(); bif.fifo_count = 5'd15; settle();
    chk_push("bp_15", 0, 8'h31);
    cyc(); bif.fifo_count = 5'd16; set_req(0, 1'b1, 8'h32, 1'b1); settle();
    chk("bp_refull_push",  32'(bif.fifo_push), 32'd0);
    chk("bp_refull_ready", 32'(bif.req_ready), 32'd0);
    cyc(); bif.fifo_count = 5'd0; settle();
    chk_push("bp_last", 0, 8'h32);
    cyc(); set_req(0, 1'b0, 8'h00, 1'b0); settle();
    chk_idle("bp_end");

    // Watchdog: requester 3 stalls after one non-last byte.
    cyc(); set_req(3, 1'b1, 8'h41, 1'b0); settle();
    chk_idle("wd_arb");
    cyc(); settle();
    chk_push("wd_b0", 3, 8'h41);
    for (int k = 1; k <= TO; k++) begin
      cyc();
      if (k == 1) set_req(3, 1'b0, 8'h00, 1'b0);
      if (k == 2) set_req(0, 1'b1, 8'h51, 1'b1);
      settle();
      chk("wd_wait_stall", 32'(bif.stall_err), 32'd0);
      chk("wd_wait_busy",  32'(bif.busy), 32'd1);
      chk("wd_wait_push",  32'(bif.fifo_push), 32'd0);
    end
    cyc(); settle();
    chk("wd_stall", 32'(bif.stall_err), 32'd1);
    chk_idle("wd_rel");
    cyc(); settle();
    chk("wd_stall_off", 32'(bif.stall_err), 32'd0);
    chk_push("wd_next", 0, 8'h51);
    cyc(); set_req(0, 1'b0, 8'h00, 1'b0); settle();
    chk_idle("wd_end");

    // Round-robin wrap with 1-byte packets from all requesters.
    cyc();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h60 + i), 1'b1);
    cyc(); rst = 1'b0; settle();
    chk_idle("rr_arb");
    for (int j = 0; j < 6; j++) begin
      cyc(); settle();
      chk_push("rr_grant", order[j], 8'(8'h60 + order[j]));
      cyc();
      if (j == 5) clear_all();
      settle();
      chk_idle("rr_gap");
    end

    // Reset on the second byte of a 4-byte packet from requester 2.
    cyc();
    set_req(2, 1'b1, 8'h71, 1'b0);
    set_req(3, 1'b1, 8'h81, 1'b1);
    settle();
    chk_idle("mr_arb");
    cyc(); settle();
    chk_push("mr_b0", 2, 8'h71);
    cyc(); set_req(2, 1'b1, 8'h72, 1'b0); rst = 1'b1; settle();
    chk_push("mr_b1", 2, 8'h72);
    cyc(); rst = 1'b0; settle();
    chk("mr_rst_grant", 32'(bif.grant_id), 32'd0);
    chk("mr_rst_stall", 32'(bif.stall_err), 32'd0);
    chk_idle("mr_rst");
    cyc(); settle();
    chk_push("mr_post", 2, 8'h72);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
